ft245_sync_device: RTL and testbench
====================================

# ft245_sync_device

Synthesizable model of the FTDI-chip side of the synchronous FT245 FIFO bus. It drives RXF#/TXE#, sources bytes onto the shared data bus when OE# is low, and captures bytes strobed by WR#. A host-side valid/ready byte stream stands in for USB. It connects pin-for-pin to the FPGA-side sync FT245 controller and is used for on-board loopback and bench verification when no FTDI part is present. Single clock domain: io_clk.

## Interface
- DEPTH_LOG2, 6: log2 of each internal buffer depth (64 bytes each).
- TXE_MARGIN, 2: free-slot threshold; io_txe_n is high when free slots in the tx buffer are fewer than this value.

- io_clk  in  1  bus clock; all logic is on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- io_d  inout  8  shared data bus; the block drives it only while reading.
- io_rxf_n  out  1  low = data available for the FPGA to read.
- io_txe_n  out  1  low = space available for the FPGA to write.
- io_rd_n  in  1  read strobe from the FPGA.
- io_wr_n  in  1  write strobe from the FPGA.
- io_oe_n  in  1  output enable from the FPGA.
- host_tx_valid / host_tx_data[7:0] / host_tx_ready  in/in/out  byte stream into the rx buffer (host to FPGA).
- host_rx_valid / host_rx_data[7:0] / host_rx_ready  out/out/in  byte stream out of the tx buffer (FPGA to host).
- stall_rx, stall_tx  in  1  force io_rxf_n / io_txe_n high, for flow-control stress.
- err_overrun  out  1  sticky; a write was strobed while the tx buffer was full.
- err_contention  out  1  sticky; io_oe_n and io_wr_n were both low on the same edge.
- rx_level, tx_level  out  DEPTH_LOG2+1  buffer occupancy.

## Operation
- Two synchronous FIFOs, each 2^DEPTH_LOG2 deep, first-word-fall-through, with binary pointers plus one wrap bit.
- rx buffer:
  - Push when host_tx_valid && host_tx_ready.
  - host_tx_ready = !rx_full. It is combinational and held 0 while rst_n is low.
- Bus drive:
  - io_d = rx head when !io_oe_n && !rx_empty.
  - Otherwise io_d = Z. It is also Z whenever io_oe_n is high, even if io_rd_n is low.
- Bus read: on posedge, if !io_rd_n && !io_oe_n && !io_rxf_n && !rx_empty, pop one byte.
  - Each consecutive cycle with RD# low pops the next byte (burst).
- Bus write: on posedge, if !io_wr_n && io_oe_n && !io_txe_n:
  - If !tx_full, push io_d into the tx buffer.
  - If tx_full, drop the byte and set err_overrun.
  - Strobes while io_txe_n is high are ignored; they are not errors.
- Contention: !io_oe_n && !io_wr_n on the same edge sets err_contention. No push occurs on that edge.
- tx buffer: host_rx_valid = !tx_empty and host_rx_data = tx head. Pop when host_rx_valid && host_rx_ready.
- Flags are registered from the post-update occupancy:
  - io_rxf_n <= (rx_level_next == 0) || stall_rx.
  - io_txe_n <= (free_next < TXE_MARGIN) || stall_tx.
- Simultaneous push and pop on either buffer: the level is unchanged and both operations succeed, including at full (pop frees the slot, push fills it) and at empty (host push while RD# is low pops nothing that cycle).
- Sticky errors clear only on reset.
- Reset mid-burst: all pointers and levels return to 0 and all buffer contents are discarded.
  - Reset values: io_rxf_n=1, io_txe_n=1, io_d=Z, host_rx_valid=0, host_tx_ready=0, err_*=0, levels=0.
  - On the first edge after release, io_txe_n goes low unless stall_tx is set; io_rxf_n stays high.

## Timing
- Host push to io_rxf_n falling: 1 io_clk edge (the flag is registered at the push edge).
- Last byte popped by the FPGA: io_rxf_n rises at that same edge.
  - An RD# held low on the next edge pops nothing, because io_rxf_n is high.
- FPGA write to host_rx_valid: visible the cycle after the push edge (FWFT).
- With TXE_MARGIN=2, one write strobed in the cycle io_txe_n rises never overruns the buffer.
- io_d drive is combinational from io_oe_n, with zero-cycle turnaround. No internal state machine is needed beyond the FIFO pointers and flag registers.

## Test plan
- Reset and idle: hold rst_n low for 3 cycles, then release → io_rxf_n=1, io_txe_n=0 after 1 edge, io_d=Z, rx_level=tx_level=0.
- Host to FPGA burst: push 0x10..0x1F from the host, then FPGA-side OE# low followed by RD# low for 16 cycles → bytes 0x10..0x1F appear on io_d in order; io_rxf_n rises on the 16th pop edge; rx_level=0.
- FPGA to host burst: 64 WR# strobes with data 0x00..0x3F, host_rx_ready=0 → io_txe_n high once tx_level=63. Then set host_rx_ready=1 → 0x00..0x3E (or ..0x3F if a 64th write was accepted) drained in order; err_overrun=0.
- Overrun: force stall_tx=0, fill the tx buffer, and strobe WR# with 0xAA while full → byte dropped, err_overrun=1, tx_level=64 unchanged.
- Contention and OE gating: drive OE# and WR# low together → err_contention=1, no push. RD# low with OE# high → no pop, io_d=Z.
- Stall and reset mid-burst: assert stall_rx during a read burst → io_rxf_n=1 next edge and pops stop. Assert rst_n low mid-burst → all reset values restored, levels=0.

Source files
------------

// File: rtl/ft245_sync_device.sv
// ft245_sync_device
//   FTDI-side model of the synchronous FT245 FIFO bus. A host byte stream
//   feeds the rx buffer, which the FPGA reads over the shared bus. Bytes the
//   FPGA writes land in the tx buffer, which drains to the host byte stream.
// Ports
//   io_clk, rst_n          clock, asynchronous active-low reset
//   io_d                   shared data bus, driven only while OE# is low
//   io_rxf_n, io_txe_n     registered bus flags (low = data / space)
//   io_rd_n, io_wr_n, io_oe_n  bus strobes from the FPGA
//   host_tx_*              valid/ready stream into the rx buffer
//   host_rx_*              valid/ready stream out of the tx buffer
//   stall_rx, stall_tx     force the matching flag high
//   err_overrun            sticky: write strobed while tx buffer full
//   err_contention         sticky: OE# and WR# low on the same edge
//   rx_level, tx_level     buffer occupancy
module ft245_sync_device #(
   parameter int DEPTH_LOG2 = 6,
   parameter int TXE_MARGIN = 2
) (
   input  logic                io_clk,
   input  logic                rst_n,
   inout  wire  [7:0]          io_d,
   output logic                io_rxf_n,
   output logic                io_txe_n,
   input  logic                io_rd_n,
   input  logic                io_wr_n,
   input  logic                io_oe_n,
   input  logic                host_tx_valid,
   input  logic [7:0]          host_tx_data,
   output logic                host_tx_ready,
   output logic                host_rx_valid,
   output logic [7:0]          host_rx_data,
   input  logic                host_rx_ready,
   input  logic                stall_rx,
   input  logic                stall_tx,
   output logic                err_overrun,
   output logic                err_contention,
   output logic [DEPTH_LOG2:0] rx_level,
   output logic [DEPTH_LOG2:0] tx_level
);
   localparam int AW    = DEPTH_LOG2;
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   // free < TXE_MARGIN  <=>  level > DEPTH - TXE_MARGIN
   localparam logic [AW:0] TXE_LIM = (AW+1)'(DEPTH - TXE_MARGIN);

   logic [7:0]  r_rx_mem [DEPTH];
   logic [7:0]  r_tx_mem [DEPTH];
   logic [AW:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
   logic        r_rxf_n, r_txe_n, r_err_ovr, r_err_cont;

   logic [AW:0] w_rx_level, w_tx_level, w_rx_level_nx, w_tx_level_nx;
   logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
   logic        w_rx_push, w_rx_pop, w_wr_ok, w_tx_push, w_tx_pop;

   // pointers carry one extra wrap bit, so the difference is the occupancy
   assign w_rx_level = r_rx_wp - r_rx_rp;
   assign w_tx_level = r_tx_wp - r_tx_rp;
   assign w_rx_empty = (w_rx_level == '0);
   assign w_tx_empty = (w_tx_level == '0);
   assign w_rx_full  = (w_rx_level == FULL);
   assign w_tx_full  = (w_tx_level == FULL);

   // ready is forced low while reset is held so the host cannot push
   assign host_tx_ready = rst_n && !w_rx_full;
   assign w_rx_push     = host_tx_valid && host_tx_ready;
   // the registered flag gates the pop, so RD# held past the last byte is inert
   assign w_rx_pop      = !io_rd_n && !io_oe_n && !r_rxf_n && !w_rx_empty;

   // a write needs OE# high; OE#+WR# together is contention and never pushes
   assign w_wr_ok   = !io_wr_n && io_oe_n && !r_txe_n;
   assign w_tx_push = w_wr_ok && !w_tx_full;
   assign w_tx_pop  = !w_tx_empty && host_rx_ready;

   assign w_rx_level_nx = w_rx_level + (AW+1)'(w_rx_push) - (AW+1)'(w_rx_pop);
   assign w_tx_level_nx = w_tx_level + (AW+1)'(w_tx_push) - (AW+1)'(w_tx_pop);

   // zero-turnaround bus drive, purely combinational from OE#
   assign io_d = (!io_oe_n && !w_rx_empty) ? r_rx_mem[r_rx_rp[AW-1:0]] : 8'hzz;

   assign host_rx_valid  = !w_tx_empty;
   assign host_rx_data   = r_tx_mem[r_tx_rp[AW-1:0]];
   assign io_rxf_n       = r_rxf_n;
   assign io_txe_n       = r_txe_n;
   assign err_overrun    = r_err_ovr;
   assign err_contention = r_err_cont;
   assign rx_level       = w_rx_level;
   assign tx_level       = w_tx_level;

   // storage needs no reset: resetting the pointers discards the contents
   always_ff @(posedge io_clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= host_tx_data;
      if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= io_d;
   end

   always_ff @(posedge io_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_wp    <= '0;
         r_rx_rp    <= '0;
         r_tx_wp    <= '0;
         r_tx_rp    <= '0;
         r_rxf_n    <= 1'b1;
         r_txe_n    <= 1'b1;
         r_err_ovr  <= 1'b0;
         r_err_cont <= 1'b0;
      end else begin
         r_rx_wp <= r_rx_wp + (AW+1)'(w_rx_push);
         r_rx_rp <= r_rx_rp + (AW+1)'(w_rx_pop);
         r_tx_wp <= r_tx_wp + (AW+1)'(w_tx_push);
         r_tx_rp <= r_tx_rp + (AW+1)'(w_tx_pop);
         // flags reflect occupancy after this edge's pushes and pops
         r_rxf_n <= (w_rx_level_nx == '0) || stall_rx;
         r_txe_n <= (w_tx_level_nx > TXE_LIM) || stall_tx;
         if (w_wr_ok && w_tx_full)  r_err_ovr  <= 1'b1;
         if (!io_oe_n && !io_wr_n)  r_err_cont <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ft245_sync_device.sv
// Bench for ft245_sync_device. Two instances share all stimulus: u0 uses the
// default TXE_MARGIN=2, u1 uses TXE_MARGIN=0 so its tx buffer can actually be
// filled from the bus and overrun. A queue-level model tracks both.
module tb_ft245_sync_device;
   logic io_clk = 1'b0;
   logic rst_n  = 1'b0;
   logic rd_n = 1'b1, wr_n = 1'b1, oe_n = 1'b1;
   logic htv = 1'b0, hrr = 1'b0, srx = 1'b0, stx = 1'b0;
   logic [7:0] htd = 8'h00, tb_d = 8'h00;

   wire  [7:0] io_d0, io_d1;
   logic [1:0] rxf_n, txe_n, htr, hrv, eov, ecn;
   logic [7:0] hrd [2];
   logic [6:0] rxl [2];
   logic [6:0] txl [2];

   int n_cmp = 0;
   int n_bad = 0;

   // the bench drives the bus only for a proper write (OE# high, WR# low)
   assign io_d0 = (oe_n && !wr_n) ? tb_d : 8'hzz;
   assign io_d1 = (oe_n && !wr_n) ? tb_d : 8'hzz;

   initial forever #5 io_clk = ~io_clk;

   ft245_sync_device #(.DEPTH_LOG2(6), .TXE_MARGIN(2)) u0 (
      .io_clk(io_clk), .rst_n(rst_n), .io_d(io_d0),
      .io_rxf_n(rxf_n[0]), .io_txe_n(txe_n[0]),
      .io_rd_n(rd_n), .io_wr_n(wr_n), .io_oe_n(oe_n),
      .host_tx_valid(htv), .host_tx_data(htd), .host_tx_ready(htr[0]),
      .host_rx_valid(hrv[0]), .host_rx_data(hrd[0]), .host_rx_ready(hrr),
      .stall_rx(srx), .stall_tx(stx),
      .err_overrun(eov[0]), .err_contention(ecn[0]),
      .rx_level(rxl[0]), .tx_level(txl[0]));

   ft245_sync_device #(.DEPTH_LOG2(6), .TXE_MARGIN(0)) u1 (
      .io_clk(io_clk), .rst_n(rst_n), .io_d(io_d1),
      .io_rxf_n(rxf_n[1]), .io_txe_n(txe_n[1]),
      .io_rd_n(rd_n), .io_wr_n(wr_n), .io_oe_n(oe_n),
      .host_tx_valid(htv), .host_tx_data(htd), .host_tx_ready(htr[1]),
      .host_rx_valid(hrv[1]), .host_rx_data(hrd[1]), .host_rx_ready(hrr),
      .stall_rx(srx), .stall_tx(stx),
      .err_overrun(eov[1]), .err_contention(ecn[1]),
      .rx_level(rxl[1]), .tx_level(txl[1]));

   // ---------------- behavioural model: ring buffers with counts ----------
   logic [7:0] m_rxb [2][64];
   logic [7:0] m_txb [2][64];
   int m_rxh [2], m_rxc [2], m_txh [2], m_txc [2];
   bit m_rxf_n [2], m_txe_n [2], m_ovr [2], m_cont [2];

   function automatic int margin(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_rxh[k] = 0; m_rxc[k] = 0; m_txh[k] = 0; m_txc[k] = 0;
         m_rxf_n[k] = 1'b1; m_txe_n[k] = 1'b1; m_ovr[k] = 1'b0; m_cont[k] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit rpush, rpop, wok, tpush, tpop;
         rpush = htv && (m_rxc[k] < 64);
         rpop  = !rd_n && !oe_n && !m_rxf_n[k] && (m_rxc[k] > 0);
         wok   = !wr_n && oe_n && !m_txe_n[k];
         tpush = wok && (m_txc[k] < 64);
         tpop  = (m_txc[k] > 0) && hrr;
         if (wok && m_txc[k] == 64) m_ovr[k] = 1'b1;
         if (!oe_n && !wr_n) m_cont[k] = 1'b1;
         if (rpop) begin m_rxh[k] = (m_rxh[k] + 1) % 64; m_rxc[k]--; end
         if (rpush) begin m_rxb[k][(m_rxh[k] + m_rxc[k]) % 64] = htd; m_rxc[k]++; end
         if (tpop) begin m_txh[k] = (m_txh[k] + 1) % 64; m_txc[k]--; end
         if (tpush) begin m_txb[k][(m_txh[k] + m_txc[k]) % 64] = tb_d; m_txc[k]++; end
         m_rxf_n[k] = (m_rxc[k] == 0) || srx;
         m_txe_n[k] = ((64 - m_txc[k]) < margin(k)) || stx;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge io_clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
      end
   endtask

   task automatic chk_bus(input int k, input bit isz, input logic [7:0] v);
      bit drv;
      drv = !oe_n && (m_rxc[k] > 0);
      if (oe_n && !wr_n) return;   // bench is driving the bus
      n_cmp++;
      if (drv && (isz || v !== m_rxb[k][m_rxh[k]])) begin
         n_bad++;
         $display("FAIL io_d[%0d] at %0t: got %0h (z=%0d), expected %0h", k, $time, v, isz, m_rxb[k][m_rxh[k]]);
      end else if (!drv && !isz) begin
         n_bad++;
         $display("FAIL io_d[%0d] at %0t: got %0h, expected Z", k, $time, v);
      end
   endtask

   initial forever begin
      @(negedge io_clk);
      for (int k = 0; k < 2; k++) begin
         chk("rxf_n", k, 32'(rxf_n[k]), 32'(m_rxf_n[k]));
         chk("txe_n", k, 32'(txe_n[k]), 32'(m_txe_n[k]));
         chk("host_tx_ready", k, 32'(htr[k]), 32'(rst_n && (m_rxc[k] < 64)));
         chk("host_rx_valid", k, 32'(hrv[k]), 32'(m_txc[k] > 0));
         if (m_txc[k] > 0) chk("host_rx_data", k, 32'(hrd[k]), 32'(m_txb[k][m_txh[k]]));
         chk("err_overrun", k, 32'(eov[k]), 32'(m_ovr[k]));
         chk("err_contention", k, 32'(ecn[k]), 32'(m_cont[k]));
         chk("rx_level", k, 32'(rxl[k]), 32'(m_rxc[k]));
         chk("tx_level", k, 32'(txl[k]), 32'(m_txc[k]));
      end
      chk_bus(0, io_d0 === 8'hzz, io_d0);
      chk_bus(1, io_d1 === 8'hzz, io_d1);
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(negedge io_clk);
      #1;
   endtask

   task automatic lit_reset_vals();
      for (int k = 0; k < 2; k++) begin
         chk("lit_rst_rxf_n", k, 32'(rxf_n[k]), 1);
         chk("lit_rst_txe_n", k, 32'(txe_n[k]), 1);
         chk("lit_rst_htr", k, 32'(htr[k]), 0);
         chk("lit_rst_hrv", k, 32'(hrv[k]), 0);
         chk("lit_rst_ovr", k, 32'(eov[k]), 0);
         chk("lit_rst_cont", k, 32'(ecn[k]), 0);
         chk("lit_rst_rxl", k, 32'(rxl[k]), 0);
         chk("lit_rst_txl", k, 32'(txl[k]), 0);
      end
   endtask

   initial begin
      // reset and idle
      repeat (3) cyc();
      lit_reset_vals();
      rst_n = 1'b1;
      cyc();
      chk("lit_txe_after_rst", 0, 32'(txe_n[0]), 0);
      chk("lit_rxf_after_rst", 0, 32'(rxf_n[0]), 1);

      // host to FPGA burst 0x10..0x1F
      for (int i = 0; i < 16; i++) begin htv = 1'b1; htd = 8'(8'h10 + i); cyc(); end
      htv = 1'b0;
      chk("lit_rx_level16", 0, 32'(rxl[0]), 16);
      chk("lit_rxf_low", 0, 32'(rxf_n[0]), 0);
      oe_n = 1'b0;
      cyc();
      chk("lit_first_byte", 0, 32'(io_d0), 32'h10);
      rd_n = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cyc();
         if (i < 15) chk("lit_burst_byte", 0, 32'(io_d0), 32'(8'h11 + i));
      end
      chk("lit_rxf_after_burst", 0, 32'(rxf_n[0]), 1);
      chk("lit_rx_empty", 0, 32'(rxl[0]), 0);
      cyc();
      rd_n = 1'b1; oe_n = 1'b1;

      // FPGA to host: 64 strobes with the host stalled
      hrr = 1'b0;
      for (int i = 0; i < 64; i++) begin wr_n = 1'b0; tb_d = 8'(i); cyc(); end
      wr_n = 1'b1;
      chk("lit_tx_level63", 0, 32'(txl[0]), 63);
      chk("lit_txe_high", 0, 32'(txe_n[0]), 1);
      chk("lit_tx_level64_m0", 1, 32'(txl[1]), 64);

      // overrun: only the margin-0 instance is full with TXE# low
      wr_n = 1'b0; tb_d = 8'hAA;
      cyc();
      wr_n = 1'b1;
      chk("lit_ovr_m2", 0, 32'(eov[0]), 0);
      chk("lit_ovr_m0", 1, 32'(eov[1]), 1);
      chk("lit_ovr_level", 1, 32'(txl[1]), 64);

      // drain to the host
      chk("lit_drain_head", 0, 32'(hrd[0]), 0);
      hrr = 1'b1;
      for (int i = 1; i <= 64; i++) begin
         cyc();
         if (i < 63) chk("lit_drain_byte", 0, 32'(hrd[0]), 32'(i));
      end
      hrr = 1'b0;
      chk("lit_drained", 0, 32'(txl[0]), 0);

      // contention, then RD# with OE# high
      oe_n = 1'b0; wr_n = 1'b0;
      cyc();
      oe_n = 1'b1; wr_n = 1'b1;
      chk("lit_contention", 0, 32'(ecn[0]), 1);
      chk("lit_cont_nopush", 0, 32'(txl[0]), 0);
      for (int i = 0; i < 4; i++) begin htv = 1'b1; htd = 8'(8'hA0 + i); cyc(); end
      htv = 1'b0;
      rd_n = 1'b0;
      repeat (3) cyc();
      chk("lit_oe_gate_level", 0, 32'(rxl[0]), 4);

      // stall during a read burst
      oe_n = 1'b0;
      cyc(); cyc();
      srx = 1'b1;
      cyc(); cyc();
      chk("lit_stall_level", 0, 32'(rxl[0]), 1);
      chk("lit_stall_rxf", 0, 32'(rxf_n[0]), 1);
      srx = 1'b0; rd_n = 1'b1; oe_n = 1'b1;
      cyc();

      // reset in the middle of a burst
      for (int i = 0; i < 8; i++) begin htv = 1'b1; htd = 8'(8'h50 + i); cyc(); end
      htv = 1'b0; oe_n = 1'b0; rd_n = 1'b0;
      cyc(); cyc();
      rst_n = 1'b0;
      cyc();
      lit_reset_vals();
      rd_n = 1'b1; oe_n = 1'b1;
      cyc();
      rst_n = 1'b1;
      cyc();

      // randomized traffic with biased fill/drain phases
      for (int n = 0; n < 3000; n++) begin
         int mode;
         bit fill;
         fill = ((n / 500) % 2) == 0;
         mode = $urandom_range(0, 9);
         rd_n = 1'b1; wr_n = 1'b1; oe_n = 1'b1;
         if (mode < 4) begin
            oe_n = 1'b0; rd_n = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         end else if (mode < 8) begin
            wr_n = 1'($urandom_range(0, 1)); tb_d = 8'($urandom);
         end else if (mode == 9) begin
            oe_n = 1'($urandom_range(0, 1)); rd_n = 1'($urandom_range(0, 1));
            wr_n = ($urandom_range(0, 7) != 0); tb_d = 8'($urandom);
         end
         htv = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         htd = 8'($urandom);
         hrr = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         srx = ($urandom_range(0, 15) == 0);
         stx = ($urandom_range(0, 15) == 0);
         rst_n = ($urandom_range(0, 599) != 0);
         cyc();
      end
      rst_n = 1'b1;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
